// File: rtl/edgedetect_frame_ctrl.sv
// Frame sequencer around the edge-detection datapath: admits one frame of pixels,
// forwards the same number of results to a valid/ready sink, flushes on abort/timeout.
module edgedetect_frame_ctrl #(
  parameter int unsigned IMG_WIDTH      = 720,
  parameter int unsigned IMG_HEIGHT     = 540,
  parameter int unsigned CNT_WIDTH      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned FLUSH_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        pipe_flush,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [23:0] src_data,
  output logic        gray_wr_en,
  input  logic        gray_full,
  output logic [23:0] gray_din,
  output logic        img_rd_en,
  input  logic        img_empty,
  input  logic [7:0]  img_dout,
  output logic        sink_valid,
  input  logic        sink_ready,
  output logic [7:0]  sink_data,
  output logic        sink_last
);

  localparam int unsigned TOTAL   = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned WDOG_W  = 16;
  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CNT_WIDTH-1:0] TOTAL_C    = CNT_WIDTH'(TOTAL);
  localparam logic [CNT_WIDTH-1:0] LAST_C     = CNT_WIDTH'(TOTAL - 1);
  localparam logic [WDOG_W-1:0]    WDOG_LIM   = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 in_run, in_act;

  // Zero-latency handshakes; abort suppresses every transfer in its cycle
  assign in_run     = (state_q == S_RUN);
  assign in_act     = in_run | (state_q == S_DRAIN);
  assign src_ready  = in_run & ~gray_full & ~abort;
  assign gray_wr_en = src_valid & src_ready;
  assign gray_din   = in_run ? src_data : '0;
  assign sink_valid = in_act & ~img_empty & (out_cnt_q < TOTAL_C) & ~abort;
  assign img_rd_en  = sink_valid & sink_ready;
  assign sink_data  = in_act ? img_dout : '0;
  assign sink_last  = sink_valid & (out_cnt_q == LAST_C);

  assign busy       = (state_q != S_IDLE);
  assign pipe_flush = (state_q == S_FLUSH);
  assign done       = done_q;
  assign error      = error_q;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    wdog_d      = wdog_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    error_d     = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wdog_d    = '0;
          error_d   = 1'b0;
        end
      end
      S_RUN, S_DRAIN: begin
        if (abort) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end else begin
          if (gray_wr_en) in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
          if (img_rd_en)  out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
          wdog_d = (gray_wr_en | img_rd_en) ? '0 : wdog_q + WDOG_W'(1);
          // Final pop wins over everything, including a skewed datapath still in RUN
          if (img_rd_en && (out_cnt_q == LAST_C)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (!(gray_wr_en | img_rd_en) && (wdog_q == WDOG_LIM)) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
            error_d     = 1'b1;
          end else if (gray_wr_en && (in_cnt_q == LAST_C)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = S_IDLE;
        else                           flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wdog_q      <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wdog_q      <= wdog_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_edgedetect_frame_ctrl.sv
// Randomized directed bench for edgedetect_frame_ctrl with a delayed-datapath model
// and a frame-level scoreboard (write order in, result order out, counts, done/last).
module tb_edgedetect_frame_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned H = 3;
  localparam int TOTAL = W * H;
  localparam int DP_LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic        busy, done, error, pipe_flush;
  logic        src_valid, src_ready;
  logic [23:0] src_data;
  logic        gray_wr_en, gray_full;
  logic [23:0] gray_din;
  logic        img_rd_en, img_empty;
  logic [7:0]  img_dout;
  logic        sink_valid, sink_ready, sink_last;
  logic [7:0]  sink_data;

  edgedetect_frame_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(8), .TIMEOUT_CYCLES(16), .FLUSH_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .pipe_flush(pipe_flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .gray_wr_en(gray_wr_en), .gray_full(gray_full), .gray_din(gray_din),
    .img_rd_en(img_rd_en), .img_empty(img_empty), .img_dout(img_dout),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data),
    .sink_last(sink_last)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] v; int t;} dp_t;
  dp_t        dpq[$];
  logic [7:0] exp_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, writes = 0, pops = 0, lasts = 0, dones = 0, flushes = 0;
  bit pend_done = 0;
  logic s_error, s_flush, s_busy;

  function automatic logic [7:0] xf(input logic [23:0] p);
    return p[7:0] ^ p[15:8] ^ p[23:16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present datapath, sample/check DUT, clock edge, update models
  task automatic tick();
    logic w, p, f;
    logic [23:0] d;
    if (dpq.size() > 0 && dpq[0].t <= cyc) begin
      img_empty = 1'b0; img_dout = dpq[0].v;
    end else begin
      img_empty = 1'b1; img_dout = 8'h00;
    end
    #1;
    w = gray_wr_en; p = img_rd_en; f = pipe_flush; d = src_data;
    s_error = error; s_flush = pipe_flush; s_busy = busy;
    chk("done_pulse", 32'(done), 32'(pend_done));
    if (pend_done) chk("busy_at_done", 32'(busy), 32'(0));
    pend_done = 0;
    if (done) dones++;
    if (gray_full)  chk("wr_while_full", 32'(w), 32'(0));
    if (!sink_ready) chk("pop_not_ready", 32'(p), 32'(0));
    if (abort) begin
      chk("wr_on_abort", 32'(w), 32'(0));
      chk("pop_on_abort", 32'(p), 32'(0));
    end
    if (writes >= TOTAL) begin
      chk("wr_past_total", 32'(w), 32'(0));
      chk("src_ready_past_total", 32'(src_ready), 32'(0));
    end
    if (f) begin
      flushes++;
      chk("flush_src_ready", 32'(src_ready), 32'(0));
      chk("flush_sink_valid", 32'(sink_valid), 32'(0));
    end
    if (w) begin
      chk("gray_din", 32'(gray_din), 32'(src_data));
      exp_q.push_back(xf(src_data));
      writes++;
    end
    if (p) begin
      chk("pop_has_data", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) chk("sink_data", 32'(sink_data), 32'(exp_q.pop_front()));
      chk("sink_last", 32'(sink_last), 32'(pops == TOTAL - 1));
      if (sink_last) lasts++;
      pops++;
      if (pops == TOTAL) pend_done = 1;
    end
    @(posedge clk);
    cyc++;
    if (f) dpq.delete();
    else begin
      if (p && dpq.size() > 0) void'(dpq.pop_front());
      if (w) dpq.push_back('{v: xf(d), t: cyc + DP_LAT});
    end
    @(negedge clk);
  endtask

  task automatic start_frame();
    writes = 0; pops = 0; lasts = 0; dones = 0;
    exp_q.delete();
    abort = 0; src_valid = 0; start = 1;
    tick();
    start = 0;
    chk("busy_after_start", 32'(busy), 32'(1));
  endtask

  task automatic run_frame(input int mode);
    for (int i = 0; i < 400 && dones == 0; i++) begin
      abort = 0; start = 0; src_data = 24'($urandom);
      if (mode == 0) begin
        src_valid = 1; gray_full = 0; sink_ready = 1;
      end else begin
        src_valid  = (writes >= TOTAL) ? 1'b1 : ($urandom_range(3) != 0);
        gray_full  = (cyc % 2 == 1);
        sink_ready = ($urandom_range(2) == 0);
      end
      tick();
    end
    chk("frame_done_count", 32'(dones), 32'(1));
    chk("frame_writes", 32'(writes), 32'(TOTAL));
    chk("frame_pops", 32'(pops), 32'(TOTAL));
    chk("frame_lasts", 32'(lasts), 32'(1));
    chk("frame_error", 32'(error), 32'(0));
    chk("frame_busy_end", 32'(busy), 32'(0));
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; src_valid = 0; src_data = '0;
    gray_full = 0; sink_ready = 0; img_empty = 1; img_dout = 8'h00;
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_error", 32'(error), 32'(0));
    chk("rst_flush", 32'(pipe_flush), 32'(0));
    chk("rst_src_ready", 32'(src_ready), 32'(0));
    chk("rst_sink_valid", 32'(sink_valid), 32'(0));
    @(negedge clk);
    rst_n = 1;
    tick();

    // Always-ready frame, then throttled frame (also offers a 13th pixel)
    start_frame(); run_frame(0);
    tick();
    start_frame(); run_frame(1);
    tick();

    // Abort while the 6th pixel is offered
    start_frame();
    for (int i = 0; i < 50; i++) begin
      src_valid = 1; gray_full = 0; sink_ready = 1; src_data = 24'($urandom);
      abort = (writes == 5);
      tick();
      if (abort) break;
    end
    abort = 0; flushes = 0;
    tick();
    chk("abort_flush_next", 32'(s_flush), 32'(1));
    for (int i = 0; i < 7; i++) tick();
    chk("abort_flush_len", 32'(flushes), 32'(4));
    chk("abort_writes", 32'(writes), 32'(5));
    chk("abort_no_done", 32'(dones), 32'(0));
    chk("abort_error", 32'(error), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));

    // Watchdog: source stalls after pixel 3, sink held off
    start_frame();
    sink_ready = 0;
    for (int i = 0; i < 20 && writes < 3; i++) begin
      src_valid = 1; src_data = 24'($urandom);
      tick();
    end
    src_valid = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("wdog_no_error_yet", 32'(s_error), 32'(0));
      chk("wdog_no_flush_yet", 32'(s_flush), 32'(0));
    end
    tick();
    chk("wdog_error_set", 32'(s_error), 32'(1));
    chk("wdog_flush_set", 32'(s_flush), 32'(1));
    for (int i = 0; i < 4; i++) tick();
    chk("wdog_busy_after", 32'(s_busy), 32'(0));
    chk("wdog_error_sticky", 32'(s_error), 32'(1));
    start_frame();
    src_valid = 0;
    tick();
    chk("start_clears_error", 32'(s_error), 32'(0));
    run_frame(0);
    tick();

    // Start pulsed during RUN, then reset asserted mid-DRAIN
    start_frame();
    for (int i = 0; i < 40 && writes < TOTAL; i++) begin
      src_valid = 1; gray_full = 0; sink_ready = 0; src_data = 24'($urandom);
      start = (writes == 4);
      tick();
    end
    start = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("drain_busy", 32'(busy), 32'(1));
    sink_ready = 1; img_empty = 1'b0; img_dout = 8'hA5;
    #1;
    chk("drain_sink_valid", 32'(sink_valid), 32'(1));
    rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_sink_valid", 32'(sink_valid), 32'(0));
    chk("arst_rd_en", 32'(img_rd_en), 32'(0));
    chk("arst_sink_last", 32'(sink_last), 32'(0));
    chk("arst_sink_data", 32'(sink_data), 32'(0));
    chk("arst_src_ready", 32'(src_ready), 32'(0));
    chk("arst_wr_en", 32'(gray_wr_en), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_flush", 32'(pipe_flush), 32'(0));
    dpq.delete();
    @(negedge clk);
    rst_n = 1;
    tick();
    start_frame(); run_frame(0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/edgedetect_frame_ctrl.md
# edgedetect_frame_ctrl

Frame-level sequencer wrapped around the edge-detection datapath (input FIFO → grayscale → sobel → output FIFO). It admits exactly one frame of IMG_WIDTH×IMG_HEIGHT 24-bit pixels into the datapath per `start`, then forwards exactly the same number of 8-bit results to a valid/ready sink, flagging the last one. It raises `done` at frame end, and flushes the datapath on abort or stall timeout.

## Interface
- IMG_WIDTH, 720, pixels per line
- IMG_HEIGHT, 540, lines per frame
- CNT_WIDTH, 20, pixel counter width; must satisfy 2^CNT_WIDTH > IMG_WIDTH×IMG_HEIGHT
- TIMEOUT_CYCLES, 65535, number of consecutive cycles with no transfer in RUN/DRAIN before error; 16-bit watchdog
- FLUSH_CYCLES, 4, length of the datapath flush pulse
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  begin a frame; sampled in IDLE only
- abort  in  1  cancel the current frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at successful frame end
- error  out  1  timeout flag; sticky until next accepted `start`
- pipe_flush  out  1  high for FLUSH_CYCLES; ORed into the datapath reset
- src_valid  in  1; src_ready  out  1; src_data  in  24  pixel source
- gray_wr_en  out  1; gray_full  in  1; gray_din  out  24  datapath input FIFO
- img_rd_en  out  1; img_empty  in  1; img_dout  in  8  datapath output FIFO, show-ahead: `img_dout` is valid while `!img_empty`, `rd_en` pops
- sink_valid  out  1; sink_ready  in  1; sink_data  out  8; sink_last  out  1  result sink

## Operation
- TOTAL = IMG_WIDTH×IMG_HEIGHT. Counters `in_cnt` and `out_cnt` are each CNT_WIDTH bits and are cleared on entry to RUN.
- States: IDLE, RUN, DRAIN, FLUSH.
- IDLE: `start` → RUN, clears `error`. `abort` is ignored.
- RUN:
  - `src_ready = !gray_full & !abort`; `gray_wr_en = src_valid & src_ready`; `gray_din = src_data`.
  - Each write increments `in_cnt`. The write that makes `in_cnt == TOTAL` moves the block to DRAIN.
- RUN and DRAIN (output side):
  - `sink_valid = !img_empty & (out_cnt < TOTAL) & !abort`; `sink_data = img_dout`.
  - `img_rd_en = sink_valid & sink_ready`; each pop increments `out_cnt`.
  - `sink_last = sink_valid & (out_cnt == TOTAL-1)`.
- DRAIN: `src_ready = 0`. The pop that makes `out_cnt == TOTAL` → IDLE with `done` = 1 for one cycle. This can occur in RUN only if the datapath is skewed; the same rule applies there.
- Abort: `abort` in RUN or DRAIN has priority over every transfer in that cycle (no write, no pop) → FLUSH.
- Watchdog: a 16-bit counter clears on any write or pop and increments otherwise in RUN/DRAIN. Reaching TIMEOUT_CYCLES sets `error` = 1 → FLUSH.
- FLUSH:
  - `pipe_flush` = 1, with all handshakes deasserted.
  - Stays FLUSH_CYCLES cycles, then → IDLE. No `done` is issued.
- `start` outside IDLE is ignored.
- When not in RUN, `src_ready`, `gray_wr_en` = 0. When not in RUN/DRAIN, `sink_valid`, `img_rd_en` = 0.

## Timing
- Reset (asynchronous, `reset` = 0): state IDLE, counters 0, `busy`/`done`/`error`/`pipe_flush` = 0. All handshake outputs are 0 (they derive from state).
- Handshake outputs are combinational from state, counters and inputs. Transfers are zero-latency pass-through.
- `start` at edge N → `busy` = 1 and `src_ready` possible in cycle N+1.
- Last pop at edge M → `done` = 1 during cycle M+1, `busy` = 0 in the same cycle.
- Abort or timeout at edge K → `pipe_flush` high for cycles K+1 … K+FLUSH_CYCLES, `busy` = 0 from K+FLUSH_CYCLES+1.
- Reset mid-frame: returns to IDLE immediately. The datapath must be reset by the same signal.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=3, always-ready source/sink, datapath model with 5-cycle delay → exactly 12 writes and 12 pops; `sink_last` only on pop 12; single `done` pulse; `busy` low the next cycle.
- Same frame with `gray_full` toggling every other cycle and `sink_ready` at a 1/3 duty → no write while full, no pop while `!sink_ready`; counts remain 12/12; no pixel lost or duplicated (check data sequence).
- A 13th pixel is offered by the source after the 12th write → `src_ready` = 0 in DRAIN; `gray_wr_en` never asserts a 13th time.
- `abort` in the same cycle as the 6th pixel is offered, with `src_valid`/`!gray_full` → no write that cycle; `pipe_flush` high exactly 4 cycles; no `done`; `error` = 0.
- TIMEOUT_CYCLES=16, source stalls after pixel 3 → `error` = 1 at cycle 16 of the stall; FLUSH follows. The next `start` clears `error`.
- `start` pulsed during RUN, and `reset` = 0 asserted mid-DRAIN → the `start` has no effect; on reset all outputs go to 0 asynchronously and the state is IDLE.
